// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq_if
// Brief    : Request/response handshake bundle for the multi-cycle mul/div unit.
// Revision : 1.0
// ============================================================================
interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid,
        input  in_ready,
        output in_op,
        output in_a,
        output in_b,
        output flush,
        input  out_valid,
        output out_ready,
        input  out_result
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_op,
        input  in_a,
        input  in_b,
        input  flush,
        output out_valid,
        input  out_ready,
        output out_result
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Brief    : RV32M/RV64M multiply/divide, one result bit per cycle, fixed latency.
// Revision : 1.0
// ============================================================================
module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    alu_muldiv_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_DIV    = 3'd4;
    localparam logic [2:0] c_OP_DIVU   = 3'd5;
    localparam logic [2:0] c_OP_REM    = 3'd6;
    localparam logic [2:0] c_OP_REMU   = 3'd7;

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            w_accept;
    logic            w_last;
    logic            w_sign_a;
    logic            w_sign_b;
    logic            w_b_zero;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_neg;

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN+1:0] w_diff;
    logic            w_fits;
    logic [XLEN-1:0] w_step_hi;
    logic [XLEN-1:0] w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_final;

    assign w_accept = bus.in_valid && (state_q == c_IDLE) && !bus.flush;
    assign w_last   = (state_q == c_BUSY) && (cnt_q == CNT_W'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = c_IDLE;
        end else begin
            case (state_q)
                c_IDLE:  if (bus.in_valid) state_d = c_BUSY;
                c_BUSY:  if (w_last)       state_d = c_DONE;
                c_DONE:  if (bus.out_ready) state_d = c_IDLE;
                default: state_d = c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure decode of state)
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = (state_q == c_IDLE);
        bus.out_valid = (state_q == c_DONE);
    end

    assign bus.out_result = result_q;

    // Operand conditioning at accept: signed operands become magnitudes,
    // and the required result negation is decided up front.
    always_comb begin
        w_sign_a = 1'b0;
        w_sign_b = 1'b0;
        case (bus.in_op)
            c_OP_MULH, c_OP_DIV, c_OP_REM: begin
                w_sign_a = bus.in_a[XLEN-1];
                w_sign_b = bus.in_b[XLEN-1];
            end
            c_OP_MULHSU: w_sign_a = bus.in_a[XLEN-1];
            default: ;
        endcase
    end

    assign w_b_zero = (bus.in_b == '0);
    assign w_mag_a  = w_sign_a ? -bus.in_a : bus.in_a;
    assign w_mag_b  = w_sign_b ? -bus.in_b : bus.in_b;

    always_comb begin
        w_neg = 1'b0;
        case (bus.in_op)
            c_OP_MULH, c_OP_MULHSU: w_neg = w_sign_a ^ w_sign_b;
            c_OP_DIV:               w_neg = (w_sign_a ^ w_sign_b) && !w_b_zero;
            c_OP_REM:               w_neg = w_sign_a;
            default:                w_neg = 1'b0;
        endcase
    end

    // Shift-add multiply step: {hi,lo} shifts right, multiplier bits exit lo.
    assign w_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});

    // Restoring divide step: hi is the partial remainder, lo collects quotient bits.
    assign w_shift = {hi_q, lo_q[XLEN-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, b_q};
    assign w_fits  = !w_diff[XLEN+1];

    always_comb begin
        if (op_q[2]) begin
            w_step_hi = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            w_step_lo = {lo_q[XLEN-2:0], w_fits};
        end else begin
            w_step_hi = w_sum[XLEN:1];
            w_step_lo = {w_sum[0], lo_q[XLEN-1:1]};
        end
    end

    assign w_prod   = {w_step_hi, w_step_lo};
    assign w_prod_s = neg_q ? -w_prod : w_prod;
    assign w_quot   = neg_q ? -w_step_lo : w_step_lo;
    assign w_rem    = neg_q ? -w_step_hi : w_step_hi;

    always_comb begin
        case (op_q)
            c_OP_MUL:                           w_final = w_prod_s[XLEN-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_final = w_prod_s[2*XLEN-1:XLEN];
            c_OP_DIV, c_OP_DIVU:                w_final = w_quot;
            default:                            w_final = w_rem;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        if (w_accept) begin
            cnt_d = CNT_W'(XLEN);
            op_d  = bus.in_op;
            neg_d = w_neg;
            hi_d  = '0;
            lo_d  = w_mag_a;
            b_d   = w_mag_b;
        end else if (state_q == c_BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            hi_d  = w_step_hi;
            lo_d  = w_step_lo;
            if (w_last && !bus.flush) begin
                result_d = w_final;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_seq
// Brief    : Directed self-checking bench for alu_muldiv_seq (XLEN = 32).
// Revision : 1.0
// ============================================================================
module tb_alu_muldiv_seq;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_muldiv_seq_if #(.XLEN(XLEN)) bus_if ();

    alu_muldiv_seq #(.XLEN(XLEN)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int cyc;
        bit rdy_seen;
        bus_if.in_op    = op;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        bus_if.in_valid = 1'b1;
        chk({tag, "/accept_ready"}, 64'(bus_if.in_ready), 64'd1);
        tick();
        bus_if.in_valid = 1'b0;
        cyc      = 0;
        rdy_seen = 1'b0;
        while (!bus_if.out_valid && cyc < 100) begin
            if (bus_if.in_ready) rdy_seen = 1'b1;
            tick();
            cyc++;
        end
        chk({tag, "/latency"}, 64'(cyc), 64'(XLEN));
        chk({tag, "/busy_ready"}, 64'(rdy_seen), 64'd0);
        chk({tag, "/done_ready"}, 64'(bus_if.in_ready), 64'd0);
        chk({tag, "/result"}, 64'(bus_if.out_result), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "/hold_valid"}, 64'(bus_if.out_valid), 64'd1);
            chk({tag, "/hold_result"}, 64'(bus_if.out_result), 64'(exp));
        end
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        chk({tag, "/consumed_valid"}, 64'(bus_if.out_valid), 64'd0);
        chk({tag, "/consumed_ready"}, 64'(bus_if.in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        bus_if.in_valid  = 1'b0;
        bus_if.in_op     = 3'd0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b0;

        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset/in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("reset/out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("reset/out_result", 64'(bus_if.out_result), 64'd0);
        tick();

        run_op("mul_7x-3",  3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("mulh_min",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        run_op("mulhsu_min",3'd2, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, 0);
        run_op("mulhu_min", 3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        run_op("div_-7/2",  3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        run_op("rem_-7/2",  3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        run_op("divu_7/2",  3'd5, 32'd7,          32'd2,         32'd3,         0);
        run_op("remu_7/2",  3'd7, 32'd7,          32'd2,         32'd1,         0);
        run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
        run_op("divu_5/0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op("remu_5/0",  3'd7, 32'd5,          32'd0,         32'd5,         0);
        run_op("backpress", 3'd0, 32'h0001_2345,  32'h0000_0010, 32'h0012_3450, 10);

        // Flush in the fifth BUSY cycle, with a competing request
        bus_if.in_op    = 3'd5;
        bus_if.in_a     = 32'd100;
        bus_if.in_b     = 32'd3;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        repeat (4) tick();
        bus_if.flush    = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_op    = 3'd0;
        bus_if.in_a     = 32'd2;
        bus_if.in_b     = 32'd2;
        tick();
        bus_if.flush    = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("flush/in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("flush/out_valid", 64'(bus_if.out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_if.out_valid) seen++;
        end
        chk("flush/no_valid", 64'(seen), 64'd0);
        chk("flush/idle_after", 64'(bus_if.in_ready), 64'd1);

        // Asynchronous reset between clock edges while BUSY
        bus_if.in_op    = 3'd0;
        bus_if.in_a     = 32'd9;
        bus_if.in_b     = 32'd9;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst/out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("arst/in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("arst/out_result", 64'(bus_if.out_result), 64'd0);
        tick();
        run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle, parametrised integer multiply/divide unit implementing the RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle combinational ALU in the execute stage.
- Uses a valid/ready handshake so the pipeline stalls while an operation is in flight.
- Uses a radix-2 shift-add multiplier and a restoring divider: one result bit per cycle, fixed latency for every operation.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_a  input  XLEN  rs1 operand.
- in_b  input  XLEN  rs2 operand.
- flush  input  1  abort any in-flight or completed-but-unconsumed operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_result  output  XLEN  result.

Behaviour:
- **Reset** (async, active-high, effective immediately):
  - state = IDLE, out_valid = 0, out_result = 0.
  - Counter and internal accumulators cleared.
  - in_ready = 1 once rst deasserts.
- **States:** IDLE, BUSY, DONE.
  - in_ready = (state == IDLE); it is a decode of state only, with no combinational path from out_ready.
  - out_valid = (state == DONE).
- **IDLE**
  - On in_valid & in_ready: latch op, operands and sign-fixup flags; load counter = XLEN; go to BUSY.
  - Operand sign handling:
    - MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - DIV/REM: both signed.
    - Signed operands are converted to magnitude at accept.
    - Negation of the result is applied at completion.
- **BUSY**
  - One iteration per cycle; counter decrements each iteration.
  - When the counter reaches 0, register the final result into out_result and go to DONE.
  - Latency: in the accept cycle N, out_valid rises in cycle N+XLEN+1, i.e. 33 cycles for XLEN=32.
  - Latency is identical for every op and every operand value, including the special cases below.
- **DONE**
  - out_result is held stable while out_valid = 1 and out_ready = 0.
  - On out_ready: go to IDLE. in_ready rises the following cycle, so there is no back-to-back accept in the handoff cycle.
- **Result selection** (2*XLEN product P):
  - MUL = P[XLEN-1:0].
  - MULH/MULHSU/MULHU = P[2*XLEN-1:XLEN].
- **Divide by zero** (b == 0):
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = in_a unchanged.
  - No exception or flag is raised.
- **Signed overflow** (DIV with a = most-negative, b = -1):
  - Quotient = most-negative.
  - REM remainder = 0.
- **Sign of result:**
  - Signed remainder takes the sign of the dividend.
  - Signed quotient is negated iff the operand signs differ and b != 0.
- **Flush:**
  - Synchronous. In any state, the next state is IDLE and out_valid = 0 next cycle; the result is discarded.
  - flush has priority over in_valid and out_ready in the same cycle; a request presented in the same cycle as flush is not accepted.
- **Illegal conditions:** in_valid while in_ready = 0 is ignored, and its operands are not sampled.
- out_result retains its last value in IDLE and BUSY; only out_valid qualifies it.

Test Plan:
- Reset, then MUL a=7, b=-3 (0xFFFFFFFD), out_ready=1 → out_valid exactly 33 cycles after accept, out_result = 0xFFFFFFEB; in_ready low throughout BUSY/DONE.
- MULH/MULHSU/MULHU with a = b = 0x80000000:
  - MULH → 0x40000000.
  - MULHSU → 0xC0000000.
  - MULHU → 0x40000000.
- DIV/REM with a=-7, b=2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIVU/REMU with a=7, b=2 → 3, 1.
- Special cases:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - All at the same 33-cycle latency.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles in DONE → out_result stable, out_valid stays 1.
  - Separate run: assert flush in BUSY cycle 5 together with in_valid → next cycle IDLE, out_valid never rises, the concurrent request is not accepted.
- Async reset mid-BUSY (rst pulsed between clock edges) → out_valid=0 and in_ready=1 with no clock edge needed after rst falls. A fresh MUL 3×4 then returns 12 with no residue from the aborted op.
